// File: rtl/data_mem_model_if.sv
// rtl/data_mem_model_if.sv - M-stage data bus between the core (master) and the data memory model (slave)
//
// Purpose: bundles the pipelined core's M-stage data-memory signals into one port.
// Signals:
//   addr      master->slave  32  byte address, bits [1:0] ignored by the memory
//   wdata     master->slave  32  write data, lanes picked by byteen
//   byteen    master->slave  4   byte write enables, bit3 = [31:24]; nonzero means write
//   rd        master->slave  1   read request (used only by registered-read memories)
//   inst_addr master->slave  32  PC of the M-stage instruction, echoed on the write trace
//   rdata     slave->master  32  read data
//   rd_valid  slave->master  1   read data valid
interface data_mem_model_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        rd;
  logic [31:0] inst_addr;
  logic [31:0] rdata;
  logic        rd_valid;

  modport master (
    output addr, wdata, byteen, rd, inst_addr,
    input  rdata, rd_valid
  );

  modport slave (
    input  addr, wdata, byteen, rd, inst_addr,
    output rdata, rd_valid
  );
endinterface

// File: rtl/data_mem_model.sv
// rtl/data_mem_model.sv - byte-enabled data memory model with clear sweep, range check and write trace
//
// Purpose: word-organised data memory for the pipelined MIPS core's M-stage bus.
// Zeroes itself by a one-word-per-cycle sweep after reset (optional), flags
// out-of-range accesses in a sticky err bit, supports read latency 0/1/2 and
// reports every committed write on a one-cycle trace port.
// Ports:
//   clk          in   clock, all state changes on posedge
//   reset        in   synchronous, active-high
//   bus          slave data bus (addr/wdata/byteen/rd/inst_addr -> rdata/rd_valid)
//   busy         out  clear sweep in progress, all accesses ignored
//   err          out  sticky out-of-range access flag, cleared only by reset
//   trace_valid  out  one-cycle pulse per committed write
//   trace_addr   out  word-aligned byte address of the committed write
//   trace_data   out  full merged word as stored
//   trace_pc     out  inst_addr of the writing instruction
module data_mem_model #(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int          DEPTH_WORDS    = 4096,
  parameter int          RD_LAT         = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_model_if.slave      bus,
  output logic                 busy,
  output logic                 err,
  output logic                 trace_valid,
  output logic [31:0]          trace_addr,
  output logic [31:0]          trace_data,
  output logic [31:0]          trace_pc
);

  localparam int              IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0]     LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [0:0]       state;
  logic [IDX_W-1:0] clr_ptr;

  logic [31:0]      diff;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             ready;
  logic             wr_req;
  logic             rd_req;
  logic             access;
  logic             wr_ok;
  logic [31:0]      old_word;
  logic [31:0]      rd_word;
  logic [31:0]      merged;

  // Read pipeline: stage 1 holds the request sampled at its edge; the output
  // register holds the last delivered word while rd_valid is low.
  logic             pipe_valid;
  logic [31:0]      pipe_data;
  logic             rv_q;
  logic [31:0]      rdata_q;

  always_comb begin
    // Unsigned subtraction folds "below base" into a huge diff, so one compare
    // covers both ends of the window.
    diff     = bus.addr - ADDR_BASE;
    in_range = {1'b0, diff} < LIMIT;
    idx      = IDX_W'(diff >> 2);
    ready    = (state == ST_READY);
    wr_req   = ready && (bus.byteen != 4'b0000);
    rd_req   = ready && bus.rd && (RD_LAT != 0);
    // With combinational reads every READY cycle is a read access.
    access   = wr_req || (ready && ((RD_LAT == 0) || bus.rd));
    wr_ok    = wr_req && in_range;
    old_word = mem[idx];
    rd_word  = in_range ? old_word : 32'h0;
    merged   = old_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.byteen[b]) merged[8*b +: 8] = bus.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) mem[clr_ptr] <= 32'h0;
      else if (wr_ok)        mem[idx]     <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_ptr     <= '0;
      err         <= 1'b0;
      trace_valid <= 1'b0;
      trace_addr  <= 32'h0;
      trace_data  <= 32'h0;
      trace_pc    <= 32'h0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == LAST_IDX) state <= ST_READY;
      end
      if (access && !in_range) err <= 1'b1;
      trace_valid <= wr_ok;
      if (wr_ok) begin
        trace_addr <= {bus.addr[31:2], 2'b00};
        trace_data <= merged;
        trace_pc   <= bus.inst_addr;
      end
    end
  end

  // Latency counts the sampling edge: RD_LAT=1 delivers in the cycle after the
  // request, RD_LAT=2 one cycle after that. Data is captured before any
  // same-edge write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      pipe_data  <= 32'h0;
      rv_q       <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      pipe_valid <= rd_req;
      pipe_data  <= rd_word;
      if (RD_LAT == 1) begin
        rv_q <= rd_req;
        if (rd_req) rdata_q <= rd_word;
      end else begin
        rv_q <= pipe_valid;
        if (pipe_valid) rdata_q <= pipe_data;
      end
    end
  end

  assign busy         = (state == ST_CLEAR);
  assign bus.rd_valid = (RD_LAT == 0) ? ready : rv_q;
  assign bus.rdata    = (RD_LAT == 0) ? (ready ? rd_word : 32'h0) : rdata_q;

endmodule

// File: tb/tb_data_mem_model.sv
// tb/tb_data_mem_model.sv - directed self-checking bench for data_mem_model
//
// Purpose: three 16-word instances (base 0 / latency 0, base 0 / latency 2,
// base 0x1000 / latency 1) share clock and reset; each task drives one scenario.
module tb_data_mem_model;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  data_mem_model_if bus_a ();
  data_mem_model_if bus_b ();
  data_mem_model_if bus_c ();

  logic        busy_a, err_a, tv_a;
  logic [31:0] ta_a, td_a, tp_a;
  logic        busy_b, err_b, tv_b;
  logic [31:0] ta_b, td_b, tp_b;
  logic        busy_c, err_c, tv_c;
  logic [31:0] ta_c, td_c, tp_c;

  data_mem_model #(.ADDR_BASE(32'h0), .DEPTH_WORDS(16), .RD_LAT(0), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a), .err(err_a),
    .trace_valid(tv_a), .trace_addr(ta_a), .trace_data(td_a), .trace_pc(tp_a));

  data_mem_model #(.ADDR_BASE(32'h0), .DEPTH_WORDS(16), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b), .err(err_b),
    .trace_valid(tv_b), .trace_addr(ta_b), .trace_data(td_b), .trace_pc(tp_b));

  data_mem_model #(.ADDR_BASE(32'h1000), .DEPTH_WORDS(16), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c), .busy(busy_c), .err(err_c),
    .trace_valid(tv_c), .trace_addr(ta_c), .trace_data(td_c), .trace_pc(tp_c));

  task automatic idle();
    bus_a.addr = 32'h0;    bus_a.wdata = 32'h0; bus_a.byteen = 4'h0; bus_a.rd = 1'b0; bus_a.inst_addr = 32'h0;
    bus_b.addr = 32'h0;    bus_b.wdata = 32'h0; bus_b.byteen = 4'h0; bus_b.rd = 1'b0; bus_b.inst_addr = 32'h0;
    bus_c.addr = 32'h1000; bus_c.wdata = 32'h0; bus_c.byteen = 4'h0; bus_c.rd = 1'b0; bus_c.inst_addr = 32'h0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    tests++; if ({err_a, err_b, err_c} !== 3'b000) begin fails++; $display("FAIL reset_err got %b exp 000", {err_a, err_b, err_c}); end
    tests++; if ({tv_a, tv_b, tv_c} !== 3'b000) begin fails++; $display("FAIL reset_trace got %b exp 000", {tv_a, tv_b, tv_c}); end
    tests++; if ({bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid} !== 3'b000) begin fails++; $display("FAIL reset_rd_valid got %b exp 000", {bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid}); end
    tests++; if (bus_b.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata_b got %h exp 00000000", bus_b.rdata); end
    reset = 1'b0;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    tests++; if (cnt !== 16) begin fails++; $display("FAIL sweep_busy_cycles got %0d exp 16", cnt); end
    tests++; if ({busy_b, busy_c} !== 2'b00) begin fails++; $display("FAIL sweep_busy_bc got %b exp 00", {busy_b, busy_c}); end
    for (int i = 0; i < 16; i++) begin
      bus_a.addr = 32'(i * 4);
      #1;
      tests++; if (bus_a.rdata !== 32'h0) begin fails++; $display("FAIL cleared_word%0d got %h exp 00000000", i, bus_a.rdata); end
      @(negedge clk);
    end
    bus_a.addr = 32'h0;
  endtask

  task automatic test_write_merge();
    @(negedge clk);
    bus_a.addr = 32'h4; bus_a.wdata = 32'hAABBCCDD; bus_a.byteen = 4'b1111; bus_a.inst_addr = 32'h0040_0100;
    @(negedge clk);
    tests++; if ({tv_a, ta_a, td_a, tp_a} !== {1'b1, 32'h4, 32'hAABBCCDD, 32'h0040_0100}) begin fails++; $display("FAIL trace_full got v=%b a=%h d=%h pc=%h exp v=1 a=00000004 d=aabbccdd pc=00400100", tv_a, ta_a, td_a, tp_a); end
    bus_a.wdata = 32'h0000_1100; bus_a.byteen = 4'b0010; bus_a.inst_addr = 32'h0040_0104;
    #1;
    tests++; if (bus_a.rdata !== 32'hAABBCCDD) begin fails++; $display("FAIL prewrite_rdata got %h exp aabbccdd", bus_a.rdata); end
    @(negedge clk);
    tests++; if ({tv_a, ta_a, td_a, tp_a} !== {1'b1, 32'h4, 32'hAABB11DD, 32'h0040_0104}) begin fails++; $display("FAIL trace_merge got v=%b a=%h d=%h pc=%h exp v=1 a=00000004 d=aabb11dd pc=00400104", tv_a, ta_a, td_a, tp_a); end
    bus_a.byteen = 4'b0000;
    #1;
    tests++; if (bus_a.rdata !== 32'hAABB11DD) begin fails++; $display("FAIL merged_rdata got %h exp aabb11dd", bus_a.rdata); end
    // misaligned address: lane picked by byteen only, trace address aligned
    bus_a.addr = 32'h6; bus_a.wdata = 32'h0000_00EE; bus_a.byteen = 4'b0001; bus_a.inst_addr = 32'h0040_0108;
    @(negedge clk);
    tests++; if ({tv_a, ta_a, td_a} !== {1'b1, 32'h4, 32'hAABB11EE}) begin fails++; $display("FAIL trace_misaligned got v=%b a=%h d=%h exp v=1 a=00000004 d=aabb11ee", tv_a, ta_a, td_a); end
    bus_a.byteen = 4'b0000;
    @(negedge clk);
    tests++; if (tv_a !== 1'b0) begin fails++; $display("FAIL trace_one_pulse got %b exp 0", tv_a); end
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL misaligned_err got %b exp 0", err_a); end
    bus_a.addr = 32'h0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); bus_b.addr = 32'h0; bus_b.wdata = 32'h1111_1111; bus_b.byteen = 4'b1111;
    @(negedge clk); bus_b.addr = 32'h4; bus_b.wdata = 32'h2222_2222;
    @(negedge clk); bus_b.addr = 32'h8; bus_b.wdata = 32'h3333_3333;
    @(negedge clk); bus_b.byteen = 4'b0000; bus_b.addr = 32'h0; bus_b.rd = 1'b1;
    @(negedge clk);
    tests++; if (bus_b.rd_valid !== 1'b0) begin fails++; $display("FAIL lat2_early_valid got %b exp 0", bus_b.rd_valid); end
    bus_b.addr = 32'h4;
    @(negedge clk);
    tests++; if ({bus_b.rd_valid, bus_b.rdata} !== {1'b1, 32'h1111_1111}) begin fails++; $display("FAIL lat2_rd0 got v=%b d=%h exp v=1 d=11111111", bus_b.rd_valid, bus_b.rdata); end
    bus_b.addr = 32'h8;
    @(negedge clk);
    tests++; if ({bus_b.rd_valid, bus_b.rdata} !== {1'b1, 32'h2222_2222}) begin fails++; $display("FAIL lat2_rd1 got v=%b d=%h exp v=1 d=22222222", bus_b.rd_valid, bus_b.rdata); end
    bus_b.rd = 1'b0;
    @(negedge clk);
    tests++; if ({bus_b.rd_valid, bus_b.rdata} !== {1'b1, 32'h3333_3333}) begin fails++; $display("FAIL lat2_rd2 got v=%b d=%h exp v=1 d=33333333", bus_b.rd_valid, bus_b.rdata); end
    @(negedge clk);
    tests++; if ({bus_b.rd_valid, bus_b.rdata} !== {1'b0, 32'h3333_3333}) begin fails++; $display("FAIL lat2_hold got v=%b d=%h exp v=0 d=33333333", bus_b.rd_valid, bus_b.rdata); end
    // same-cycle write and read of word 1
    bus_b.addr = 32'h4; bus_b.wdata = 32'hDEAD_BEEF; bus_b.byteen = 4'b1111; bus_b.rd = 1'b1;
    @(negedge clk);
    tests++; if ({tv_b, td_b} !== {1'b1, 32'hDEAD_BEEF}) begin fails++; $display("FAIL lat2_trace got v=%b d=%h exp v=1 d=deadbeef", tv_b, td_b); end
    bus_b.byteen = 4'b0000;
    @(negedge clk);
    tests++; if ({bus_b.rd_valid, bus_b.rdata} !== {1'b1, 32'h2222_2222}) begin fails++; $display("FAIL read_before_write got v=%b d=%h exp v=1 d=22222222", bus_b.rd_valid, bus_b.rdata); end
    bus_b.rd = 1'b0;
    @(negedge clk);
    tests++; if ({bus_b.rd_valid, bus_b.rdata} !== {1'b1, 32'hDEAD_BEEF}) begin fails++; $display("FAIL read_after_write got v=%b d=%h exp v=1 d=deadbeef", bus_b.rd_valid, bus_b.rdata); end
    bus_b.addr = 32'h0;
  endtask

  task automatic test_range();
    @(negedge clk);
    bus_c.addr = 32'h1000; bus_c.wdata = 32'h1234_5678; bus_c.byteen = 4'b1111;
    @(negedge clk);
    tests++; if ({tv_c, ta_c, err_c} !== {1'b1, 32'h1000, 1'b0}) begin fails++; $display("FAIL range_base_write got v=%b a=%h err=%b exp v=1 a=00001000 err=0", tv_c, ta_c, err_c); end
    bus_c.addr = 32'h0FFC; bus_c.wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    tests++; if ({tv_c, err_c} !== 2'b01) begin fails++; $display("FAIL range_below got v=%b err=%b exp v=0 err=1", tv_c, err_c); end
    bus_c.addr = 32'h1040;
    @(negedge clk);
    tests++; if (tv_c !== 1'b0) begin fails++; $display("FAIL range_above_trace got %b exp 0", tv_c); end
    bus_c.addr = 32'h103C; bus_c.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    tests++; if ({tv_c, ta_c, td_c} !== {1'b1, 32'h103C, 32'hCAFE_F00D}) begin fails++; $display("FAIL range_top_write got v=%b a=%h d=%h exp v=1 a=0000103c d=cafef00d", tv_c, ta_c, td_c); end
    bus_c.byteen = 4'b0000; bus_c.addr = 32'h1000; bus_c.rd = 1'b1;
    @(negedge clk);
    tests++; if ({bus_c.rd_valid, bus_c.rdata} !== {1'b1, 32'h1234_5678}) begin fails++; $display("FAIL range_intact got v=%b d=%h exp v=1 d=12345678", bus_c.rd_valid, bus_c.rdata); end
    bus_c.addr = 32'h1040;
    @(negedge clk);
    tests++; if ({bus_c.rd_valid, bus_c.rdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL range_oor_read got v=%b d=%h exp v=1 d=00000000", bus_c.rd_valid, bus_c.rdata); end
    bus_c.addr = 32'h103C;
    @(negedge clk);
    tests++; if (bus_c.rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL range_top_read got %h exp cafef00d", bus_c.rdata); end
    bus_c.rd = 1'b0; bus_c.addr = 32'h1000;
    repeat (3) @(negedge clk);
    tests++; if ({err_c, bus_c.rd_valid, bus_c.rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin fails++; $display("FAIL range_sticky got err=%b v=%b d=%h exp err=1 v=0 d=cafef00d", err_c, bus_c.rd_valid, bus_c.rdata); end
  endtask

  task automatic test_busy_write();
    int cnt;
    int traces;
    pulse_reset();
    bus_a.addr = 32'h4;
    #1;
    tests++; if ({bus_a.rd_valid, bus_a.rdata} !== {1'b0, 32'h0}) begin fails++; $display("FAIL busy_read got v=%b d=%h exp v=0 d=00000000", bus_a.rd_valid, bus_a.rdata); end
    tests++; if (err_c !== 1'b0) begin fails++; $display("FAIL err_cleared_by_reset got %b exp 0", err_c); end
    repeat (3) @(negedge clk);
    bus_a.addr = 32'h0; bus_a.wdata = 32'h5555_5555; bus_a.byteen = 4'b1111; bus_a.inst_addr = 32'h0040_0200;
    traces = 0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (tv_a === 1'b1) traces++;
    end
    bus_a.byteen = 4'b0000;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin
      cnt++; @(negedge clk);
      if (tv_a === 1'b1) traces++;
    end
    tests++; if (traces !== 0) begin fails++; $display("FAIL busy_trace got %0d exp 0", traces); end
    tests++; if (cnt !== 2) begin fails++; $display("FAIL busy_tail_cycles got %0d exp 2", cnt); end
    #1;
    tests++; if (bus_a.rdata !== 32'h0) begin fails++; $display("FAIL busy_write_dropped got %h exp 00000000", bus_a.rdata); end
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL busy_err got %b exp 0", err_a); end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    pulse_reset();
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL midsweep_busy got %b exp 1", busy_a); end
    reset = 1'b0;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    tests++; if (cnt !== 16) begin fails++; $display("FAIL midsweep_restart_cycles got %0d exp 16", cnt); end
    bus_a.addr = 32'h3C;
    #1;
    tests++; if ({bus_a.rd_valid, bus_a.rdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL midsweep_last_word got v=%b d=%h exp v=1 d=00000000", bus_a.rd_valid, bus_a.rdata); end
    bus_a.addr = 32'h0;
  endtask

  initial begin
    idle();
    test_reset();
    test_write_merge();
    test_back_to_back();
    test_range();
    test_busy_write();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end
endmodule
